// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
//   Brings the glitchy, clk-asynchronous output of an upstream ripple counter
//   into the clk domain as a clean count. Each bit is double-flopped, and a
//   stability filter only accepts a synced value once it has stayed unchanged
//   for STABLE_CYC consecutive samples. Each accepted change reports its
//   increment, detects wrap, checks against a compare value, and adds the
//   increment to a saturating running total.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   cnt_in     in   W      raw ripple-counter value (asynchronous to clk)
//   cmp_value  in   W      compare value
//   cmp_en     in   1      enables the match output
//   clr        in   1      synchronous clear of total and total_sat
//   cnt_q      out  W      last accepted, settled count
//   cnt_valid  out  1      high once the first value has been accepted
//   upd        out  1      one-cycle pulse when cnt_q changes while tracking
//   delta      out  W      (new - old) mod 2^W of the latest update, held
//   wrap       out  1      one-cycle pulse with upd when new < old
//   match      out  1      one-cycle pulse when an accepted value equals cmp_value
//   total      out  ACC_W  saturating sum of all deltas
//   total_sat  out  1      sticky flag, set when total saturates
module ripple_count_sampler #(
  parameter int W          = 4,
  parameter int STABLE_CYC = 2,
  parameter int ACC_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     cnt_in,
  input  logic [W-1:0]     cmp_value,
  input  logic             cmp_en,
  input  logic             clr,
  output logic [W-1:0]     cnt_q,
  output logic             cnt_valid,
  output logic             upd,
  output logic [W-1:0]     delta,
  output logic             wrap,
  output logic             match,
  output logic [ACC_W-1:0] total,
  output logic             total_sat
);

  localparam int RUN_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Synchroniser and filter state
  logic [W-1:0]     s1;
  logic [W-1:0]     s2;
  logic [W-1:0]     s2_d;
  logic [2:0]       fill;     // fill[k]: stage k (s1, s2, s2_d) holds a post-reset sample
  logic [RUN_W-1:0] run;
  logic             settled;

  // FSM and next-value signals
  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             upd_nxt;
  logic             wrap_nxt;
  logic             match_nxt;
  logic [W-1:0]     delta_new;
  logic [ACC_W-1:0] total_base;
  logic [ACC_W:0]   total_sum;
  logic [ACC_W-1:0] total_nxt;
  logic             sat_nxt;

  // Two-flop synchroniser, previous-sample register and stability run counter.
  // Without the fill tracking, the reset zeros in s2/s2_d would look like a
  // settled value of 0 and be accepted before the real input arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      s2_d <= '0;
      fill <= 3'b000;
      run  <= '0;
    end else begin
      s1   <= cnt_in;
      s2   <= s1;
      s2_d <= s2;
      fill <= {fill[1:0], 1'b1};
      if (!fill[2] || (s2 != s2_d)) begin
        run <= '0;
      end else if (run != RUN_MAX) begin
        run <= run + 1'b1;
      end else begin
        run <= run;
      end
    end
  end

  assign settled = fill[2] && (run == RUN_MAX) && (s2 == s2_d);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic: leave EMPTY on the first settled value
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (settled) begin
          state_nxt = TRACK;
        end else begin
          state_nxt = EMPTY;
        end
      end
      TRACK:   state_nxt = TRACK;
      default: state_nxt = EMPTY;
    endcase
  end

  // FSM output logic: acceptance, pulses and saturating total
  always_comb begin
    delta_new = s2 - cnt_q;
    accept    = 1'b0;
    upd_nxt   = 1'b0;
    case (state)
      EMPTY: begin
        accept  = settled;
        upd_nxt = 1'b0;
      end
      TRACK: begin
        accept  = settled && (s2 != cnt_q);
        upd_nxt = settled && (s2 != cnt_q);
      end
      default: begin
        accept  = 1'b0;
        upd_nxt = 1'b0;
      end
    endcase
    wrap_nxt  = upd_nxt && (s2 < cnt_q);
    match_nxt = accept && cmp_en && (s2 == cmp_value);

    // clr takes effect before the add, so clr with upd leaves total = delta
    total_base = clr ? '0 : total;
    if (upd_nxt) begin
      total_sum = {1'b0, total_base} + (ACC_W + 1)'(delta_new);
    end else begin
      total_sum = {1'b0, total_base};
    end
    if (total_sum[ACC_W]) begin
      total_nxt = '1;
      sat_nxt   = 1'b1;
    end else begin
      total_nxt = total_sum[ACC_W-1:0];
      sat_nxt   = clr ? 1'b0 : total_sat;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      cnt_valid <= 1'b0;
      upd       <= 1'b0;
      delta     <= '0;
      wrap      <= 1'b0;
      match     <= 1'b0;
      total     <= '0;
      total_sat <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q     <= s2;
        cnt_valid <= 1'b1;
      end else begin
        cnt_q     <= cnt_q;
        cnt_valid <= cnt_valid;
      end
      if (upd_nxt) begin
        delta <= delta_new;
      end else begin
        delta <= delta;
      end
      upd       <= upd_nxt;
      wrap      <= wrap_nxt;
      match     <= match_nxt;
      total     <= total_nxt;
      total_sat <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
module tb_ripple_count_sampler;

  logic        clk;
  logic        reset;
  logic [3:0]  cnt_in;
  logic [3:0]  cmp_value;
  logic        cmp_en;
  logic        clr;
  logic [3:0]  cnt_q;
  logic        cnt_valid;
  logic        upd;
  logic [3:0]  delta;
  logic        wrap;
  logic        match;
  logic [15:0] total;
  logic        total_sat;

  // Second instance with a 4-bit total for saturation checks
  logic [3:0]  cnt_in2;
  logic        clr2;
  logic [3:0]  cmp_value2;
  logic        cmp_en2;
  logic [3:0]  cnt_q2;
  logic        cnt_valid2;
  logic        upd2;
  logic [3:0]  delta2;
  logic        wrap2;
  logic        match2;
  logic [3:0]  total2;
  logic        total_sat2;

  int passed;
  int checks;
  int n_upd;
  int n_wrap;
  int n_match;
  int n_match_upd;

  ripple_count_sampler #(.W(4), .STABLE_CYC(2), .ACC_W(16)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cmp_value(cmp_value),
    .cmp_en(cmp_en), .clr(clr), .cnt_q(cnt_q), .cnt_valid(cnt_valid),
    .upd(upd), .delta(delta), .wrap(wrap), .match(match),
    .total(total), .total_sat(total_sat)
  );

  ripple_count_sampler #(.W(4), .STABLE_CYC(2), .ACC_W(4)) dut2 (
    .clk(clk), .reset(reset), .cnt_in(cnt_in2), .cmp_value(cmp_value2),
    .cmp_en(cmp_en2), .clr(clr2), .cnt_q(cnt_q2), .cnt_valid(cnt_valid2),
    .upd(upd2), .delta(delta2), .wrap(wrap2), .match(match2),
    .total(total2), .total_sat(total_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive cnt_in at a negedge and observe n cycles, counting pulses at each negedge
  task automatic hold(input logic [3:0] v, input int n);
    cnt_in      = v;
    n_upd       = 0;
    n_wrap      = 0;
    n_match     = 0;
    n_match_upd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (upd)         n_upd++;
      if (wrap)        n_wrap++;
      if (match)       n_match++;
      if (match & upd) n_match_upd++;
    end
  endtask

  task automatic hold2(input logic [3:0] v, input int n);
    cnt_in2 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cnt_in = 4'd5;
    @(negedge clk);
    checks++;
    if ({cnt_q, cnt_valid, upd, delta, wrap, match, total, total_sat} !== 28'd0)
      $display("FAIL reset_state: got %h expected 0",
               {cnt_q, cnt_valid, upd, delta, wrap, match, total, total_sat});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);   // edges 0..3
    chk("latency_valid_edge3", cnt_valid, 1'b0);
    @(negedge clk);              // edge 4
    chk("latency_valid_edge4", cnt_valid, 1'b1);
    chk("latency_cnt_q", cnt_q, 4'd5);
    chk("first_accept_upd", upd, 1'b0);
    chk("first_accept_total", total, 16'd0);
  endtask

  task automatic test_steps;
    hold(4'd6, 6);
    chk("step6_upd_count", n_upd, 1);
    chk("step6_delta", delta, 4'd1);
    hold(4'd7, 6);
    chk("step7_upd_count", n_upd, 1);
    chk("step7_wrap_count", n_wrap, 0);
    chk("step7_delta", delta, 4'd1);
    chk("step7_total", total, 16'd2);
  endtask

  task automatic test_wrap;
    hold(4'd14, 6);
    chk("to14_delta", delta, 4'd7);
    chk("to14_wrap_count", n_wrap, 0);
    chk("to14_total", total, 16'd9);
    hold(4'd1, 6);
    chk("wrap_upd_count", n_upd, 1);
    chk("wrap_wrap_count", n_wrap, 1);
    chk("wrap_delta", delta, 4'd3);
    chk("wrap_total", total, 16'd12);
  endtask

  task automatic test_glitch;
    int toggles_upd;
    toggles_upd = 0;
    for (int i = 0; i < 10; i++) begin
      cnt_in = (i % 2 == 1) ? 4'd11 : 4'd3;
      @(negedge clk);
      if (upd) toggles_upd++;
    end
    chk("toggle_no_upd", toggles_upd, 0);
    chk("toggle_cnt_q_held", cnt_q, 4'd1);
    hold(4'd4, 8);
    chk("settle_upd_count", n_upd, 1);
    chk("settle_cnt_q", cnt_q, 4'd4);
    chk("settle_delta", delta, 4'd3);
    chk("settle_total", total, 16'd15);
  endtask

  task automatic test_saturate;
    chk("acc4_start_valid", cnt_valid2, 1'b1);
    chk("acc4_start_total", total2, 4'd0);
    hold2(4'd7, 6);
    chk("acc4_total7", total2, 4'd7);
    hold2(4'd14, 6);
    chk("acc4_total14", total2, 4'd14);
    chk("acc4_not_sat", total_sat2, 1'b0);
    hold2(4'd1, 6);
    chk("acc4_total_sat_val", total2, 4'd15);
    chk("acc4_sat_flag", total_sat2, 1'b1);
    // Step to 3 and assert clr on exactly the edge that registers the update
    cnt_in2 = 4'd3;
    repeat (4) @(negedge clk);   // edges 0..3
    clr2 = 1'b1;
    @(negedge clk);              // edge 4
    clr2 = 1'b0;
    chk("clr_upd_pulse", upd2, 1'b1);
    chk("clr_upd_total", total2, 4'd2);
    chk("clr_upd_sat", total_sat2, 1'b0);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    chk("clr_alone_total", total2, 4'd0);
  endtask

  task automatic test_match_and_reset;
    int rst_upd;
    cmp_value = 4'd9;
    cmp_en    = 1'b1;
    hold(4'd9, 6);
    chk("match_count", n_match, 1);
    chk("match_with_upd", n_match_upd, 1);
    chk("match_total", total, 16'd20);
    cmp_en = 1'b0;
    hold(4'd5, 6);
    chk("to5_wrap_count", n_wrap, 1);
    chk("to5_total", total, 16'd32);
    hold(4'd9, 6);
    chk("disabled_match_count", n_match, 0);
    chk("disabled_upd_count", n_upd, 1);
    chk("disabled_total", total, 16'd36);
    // Reset while a new value is still in the filter
    cnt_in = 4'd2;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rst_upd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (upd) rst_upd++;
    end
    chk("midreset_no_pulse", rst_upd, 0);
    checks++;
    if ({cnt_q, cnt_valid, upd, delta, wrap, match, total, total_sat} !== 28'd0)
      $display("FAIL midreset_state: got %h expected 0",
               {cnt_q, cnt_valid, upd, delta, wrap, match, total, total_sat});
    else passed++;
    // Back in EMPTY: first acceptance gives no upd, but match may fire
    cmp_value = 4'd2;
    cmp_en    = 1'b1;
    reset     = 1'b0;
    hold(4'd2, 8);
    chk("reacquire_valid", cnt_valid, 1'b1);
    chk("reacquire_cnt_q", cnt_q, 4'd2);
    chk("reacquire_no_upd", n_upd, 0);
    chk("reacquire_match", n_match, 1);
    chk("reacquire_total", total, 16'd0);
  endtask

  initial begin
    passed     = 0;
    checks     = 0;
    reset      = 1'b1;
    cnt_in     = 4'd5;
    cmp_value  = 4'd0;
    cmp_en     = 1'b0;
    clr        = 1'b0;
    cnt_in2    = 4'd0;
    clr2       = 1'b0;
    cmp_value2 = 4'd0;
    cmp_en2    = 1'b0;
    test_reset;
    test_steps;
    test_wrap;
    test_glitch;
    test_saturate;
    test_match_and_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
